// File: rtl/rs232_to_axis.sv
// RS232 8N1 receiver: 2-FF synchronised rxd_pin into a small FIFO byte stream; ovalid one clock after the stop sample.
// Holds odata while oready is low; rtsn_pin asserts near full. `RS232RX_FRAMING_CHECK_EN adds framing-error drop and BREAK.
module rs232_to_axis #(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  FIFO_DEPTH = 4,
  parameter int  RTS_SLACK  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_pin,
  output logic       rtsn_pin,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       ferror,
  output logic       overrun
);

  localparam int BAUD_COUNT = $rtoi(CLOCK_FREQ / BAUD_RATE);
  localparam int CW         = $clog2(BAUD_COUNT);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int NW         = AW + 1;

  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_COUNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_COUNT - 1);
  localparam logic [NW-1:0] DEPTH_C   = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] RTS_TH    = NW'(FIFO_DEPTH - RTS_SLACK);

`ifdef RS232RX_FRAMING_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [NW-1:0] count_q;
  logic [NW-1:0] count_d;
  logic          rtsn_q;
  logic          overrun_q;

  logic rxd, tick, stop_tick, stop_good, pop, push, drop, full;

  always_comb begin
    rxd       = sync_q[1];
    tick      = (baud_q == '0);
    stop_tick = (state_q == S_STOP) && tick;
`ifdef RS232RX_FRAMING_CHECK_EN
    stop_good = stop_tick && rxd;
`else
    stop_good = stop_tick;
`endif
    full    = (count_q == DEPTH_C);
    pop     = ovalid && oready;
    // A simultaneous pop frees the slot, so a full FIFO still takes the byte.
    push    = stop_good && (!full || pop);
    drop    = stop_good && full && !pop;
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + NW'(1);
    else if (!push && pop)
      count_d = count_q - NW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      rtsn_q    <= 1'b1;
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q <= {sync_q[0], rxd_pin};
      if (!tick) baud_q <= baud_q - CW'(1);
      case (state_q)
        S_IDLE: begin
          if (!rxd) begin
            baud_q  <= HALF_LOAD;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (!rxd) begin
              baud_q  <= FULL_LOAD;
              bit_q   <= '0;
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shift_q <= {rxd, shift_q[7:1]};
            baud_q  <= FULL_LOAD;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
`ifdef RS232RX_FRAMING_CHECK_EN
          if (tick) state_q <= rxd ? S_IDLE : S_BREAK;
`else
          if (tick) state_q <= S_IDLE;
`endif
        end
`ifdef RS232RX_FRAMING_CHECK_EN
        S_BREAK: begin
          if (rxd) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase

      if (push) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      count_q   <= count_d;
      rtsn_q    <= (count_d >= RTS_TH);
      overrun_q <= drop;
    end
  end

`ifdef RS232RX_FRAMING_CHECK_EN
  logic ferror_q;
  always_ff @(posedge clock) begin
    if (reset) ferror_q <= 1'b0;
    else       ferror_q <= stop_tick && !rxd;
  end
  assign ferror = ferror_q;
`else
  assign ferror = 1'b0;
`endif

  assign ovalid   = (count_q != '0);
  assign odata    = mem_q[rd_q];
  assign rtsn_pin = rtsn_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_rs232_to_axis.sv
// Bench for rs232_to_axis at 16 clocks per bit: a serial driver feeds frames, a negedge monitor
// pops expected bytes from a scoreboard queue whenever ovalid && oready.
module tb_rs232_to_axis;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       rxd_pin = 1'b1;
  logic       oready  = 1'b0;
  logic       rtsn_pin;
  logic [7:0] odata;
  logic       ovalid;
  logic       ferror;
  logic       overrun;

  rs232_to_axis #(
    .CLOCK_FREQ(1600000.0),
    .BAUD_RATE (100000.0),
    .FIFO_DEPTH(4),
    .RTS_SLACK (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rxd_pin (rxd_pin),
    .rtsn_pin(rtsn_pin),
    .odata   (odata),
    .ovalid  (ovalid),
    .oready  (oready),
    .ferror  (ferror),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] dat;
    bit         lat;
    logic [7:0] exp_dat;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %0h, expected none", odata);
        end else begin
          check("odata", {24'd0, odata}, {24'd0, exp_q.pop_front()});
        end
      end
      if (ferror)  ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_values();
    check("rst_rtsn",    {31'd0, rtsn_pin}, 32'd1);
    check("rst_ovalid",  {31'd0, ovalid},   32'd0);
    check("rst_odata",   {24'd0, odata},    32'd0);
    check("rst_ferror",  {31'd0, ferror},   32'd0);
    check("rst_overrun", {31'd0, overrun},  32'd0);
  endtask

  // Slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit; each slot is 16 clocks.
  // The stop bit is sampled 11 clocks into slot 9 (2 sync + 1 detect + 8 half-bit).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit lat, input int rst_slot);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      rxd_pin = bits[s];
      for (int j = 1; j <= 16; j++) begin
        @(posedge clock);
        #1;
        if (s == rst_slot && j == 8) reset = 1'b1;
        if (s == rst_slot && j == 9) begin
          check_reset_values();
          exp_q.delete();
          reset = 1'b0;
        end
        if (s == rst_slot && j == 10)
          check("rtsn_release", {31'd0, rtsn_pin}, 32'd0);
        if (lat && s == 9) begin
          if (j == 10) check("lat_before", {31'd0, ovalid}, 32'd0);
          if (j == 11) begin
            check("lat_ovalid",  {31'd0, ovalid},  32'd1);
            check("lat_odata",   {24'd0, odata},   {24'd0, b});
            check("lat_ferror",  {31'd0, ferror},  32'd0);
            check("lat_overrun", {31'd0, overrun}, 32'd0);
          end
          if (j == 12) check("lat_one_cycle", {31'd0, ovalid}, 32'd0);
        end
      end
    end
  endtask

  initial begin
    int         f0;
    int         o0;
    int         vcnt;
    logic [7:0] fc_bytes [5];
    logic       fc_rtsn  [5];
    logic       drain_rtsn [4];

    vecs[0] = '{dat: 8'hA5, lat: 1'b1, exp_dat: 8'hA5};
    vecs[1] = '{dat: 8'h00, lat: 1'b0, exp_dat: 8'h00};
    vecs[2] = '{dat: 8'hFF, lat: 1'b0, exp_dat: 8'hFF};
    vecs[3] = '{dat: 8'h81, lat: 1'b0, exp_dat: 8'h81};
    vecs[4] = '{dat: 8'h7E, lat: 1'b0, exp_dat: 8'h7E};
    fc_bytes   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    fc_rtsn    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    drain_rtsn = '{1'b1, 1'b1, 1'b0, 1'b0};

    idle(3);
    check_reset_values();
    reset = 1'b0;
    idle(1);
    check("rtsn_after_reset", {31'd0, rtsn_pin}, 32'd0);
    idle(5);

    // Back-to-back frames with no idle gap, including 0x00 followed by 0xFF.
    oready = 1'b1;
    f0 = ferr_cnt;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp_dat);
      send_frame(vecs[i].dat, 1'b1, vecs[i].lat, -1);
    end
    idle(40);
    check("table_sb_empty", exp_q.size(), 32'd0);
    check("table_no_ferror", ferr_cnt - f0, 32'd0);

    // Short low glitch must not produce a byte; the next frame still decodes.
    rxd_pin = 1'b0;
    idle(4);
    rxd_pin = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (ovalid) vcnt++;
    end
    check("glitch_no_ovalid", vcnt, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle(40);
    check("glitch_sb_empty", exp_q.size(), 32'd0);

    // Flow control and overrun with the sink stalled.
    oready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(fc_bytes[i]);
      send_frame(fc_bytes[i], 1'b1, 1'b0, -1);
      check("fc_rtsn", {31'd0, rtsn_pin}, {31'd0, fc_rtsn[i]});
    end
    check("fc_overrun", ovr_cnt - o0, 32'd1);
    check("fc_hold_odata", {24'd0, odata}, 32'h01);
    oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("drain_rtsn", {31'd0, rtsn_pin}, {31'd0, drain_rtsn[i]});
    end
    check("drain_sb_empty", exp_q.size(), 32'd0);
    check("drain_ovalid", {31'd0, ovalid}, 32'd0);
    idle(20);

    // Zero stop bit then the line held low for 30 bit times in total. Without the
    // framing check the receiver keeps framing the low line as 0x00 bytes; the frame
    // that starts just before the line returns high reads as 0xFF.
    f0 = ferr_cnt;
`ifndef RS232RX_FRAMING_CHECK_EN
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
`endif
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(464);
    rxd_pin = 1'b1;
    idle(300);
`ifdef RS232RX_FRAMING_CHECK_EN
    check("frame_ferror", ferr_cnt - f0, 32'd1);
`else
    check("frame_ferror", ferr_cnt - f0, 32'd0);
`endif
    check("frame_sb_empty", exp_q.size(), 32'd0);

    // Reset during data bit 4 with one byte already buffered.
    oready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    check("prefill_ovalid", {31'd0, ovalid}, 32'd1);
    send_frame(8'hF0, 1'b1, 1'b0, 5);
    check("post_rst_ovalid", {31'd0, ovalid}, 32'd0);
    oready = 1'b1;
    idle(40);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    idle(40);
    check("rst_sb_empty", exp_q.size(), 32'd0);
    check("total_overrun", ovr_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
